fb_scan_arbiter: RTL and testbench
==================================

# fb_scan_arbiter

Owns the single-port framebuffer RAM and shares it between the VGA scan-out and the GPU core. Runs in the system `clk` domain alongside `clk_div2`/`vga_sync`. Tracks the pixel phase itself and gives display fetch a guaranteed slot every active pixel. All remaining cycles go to GPU write and read requests, arbitrated round-robin.

## Interface
Parameters:
- `FB_W`, 160, framebuffer width in words (4x horizontal downscale of 640)
- `FB_H`, 120, framebuffer height in words (4x vertical downscale of 480)
- `ADDR_W`, 15, RAM word address width (must satisfy 2^ADDR_W >= FB_W*FB_H)
- `DATA_W`, 8, pixel/word width (RGB332)

Ports:
- `clk`  in  1  system clock (2x pixel clock)
- `rst`  in  1  asynchronous, active-low reset
- `blank_n`  in  1  from vga_sync, 1 = active video
- `point_pos_x`  in  10  current pixel column from vga_sync
- `point_pos_y`  in  10  current pixel row from vga_sync
- `wr_valid` / `wr_ready`  in / out  1  GPU write handshake
- `wr_addr`  in  ADDR_W  GPU write word address
- `wr_data`  in  DATA_W  GPU write data
- `rd_valid` / `rd_ready`  in / out  1  GPU read-request handshake
- `rd_addr`  in  ADDR_W  GPU read word address
- `rd_resp_valid`  out  1  one-cycle pulse, `rd_data` valid
- `rd_data`  out  DATA_W  GPU read data
- `mem_en`, `mem_we`  out  1  RAM enable / write enable
- `mem_addr`  out  ADDR_W  RAM address
- `mem_wdata`  out  DATA_W  RAM write data
- `mem_rdata`  in  DATA_W  RAM read data (1-cycle synchronous read)
- `pixel`  out  DATA_W  colour for the DAC
- `addr_err`  out  1  sticky flag for an out-of-range GPU address

## Operation
- Phase bit `ph`:
  - resets to 0 and toggles every `clk`.
  - Stays aligned with `vga_clk` because `clk_div2` resets to 0 on the same `rst` (`ph==0` ⇔ `vga_clk` low).
- Display slot (`ph==0 && blank_n==1`):
  - `mem_en=1`, `mem_we=0`.
  - `mem_addr = (point_pos_y>>2)*FB_W + (point_pos_x>>2)`, computed as `(y'<<7)+(y'<<5)+x'`. Width is ADDR_W, no truncation for in-range positions.
  - Both GPU readies = 0.
- GPU slot (`ph==1`, or `blank_n==0`):
  - If only one of wr/rd is valid, that request is granted.
  - If both are valid, the one whose turn it is under the `rr` bit wins. `rr` resets to write-first and flips after each grant made while both were valid.
  - `wr_ready`/`rd_ready` are combinational from slot, valid bits and `rr`. A requester must hold valid/addr/data until its ready is high.
  - Granted write: `mem_en=1`, `mem_we=1`, `mem_addr=wr_addr`, `mem_wdata=wr_data`.
  - Granted read: `mem_en=1`, `mem_we=0`, `mem_addr=rd_addr`.
- Out-of-range address (>= FB_W*FB_H):
  - The request is still accepted (ready=1).
  - `mem_en` stays 0, `addr_err` is set and held until reset.
  - A read returns `rd_data=0` with a normal `rd_resp_valid` pulse.
- Read return:
  - A 1-deep tag register records the slot owner (none/display/gpu).
  - The next cycle, `mem_rdata` goes to `pixel` (display tag) or to `rd_data` with `rd_resp_valid=1` (gpu tag).
- Blanking: `pixel` is forced to 0 at the next `ph==1` edge after `blank_n` drops.
- Idle cycles: `mem_en=0`. `mem_addr`/`mem_wdata` hold their last value.

## Timing
- Reset (`rst` low, asynchronous):
  - `ph=0`, `rr`=write-first, tag=none.
  - `pixel=0`, `rd_data=0`, `rd_resp_valid=0`, `addr_err=0`.
  - `mem_en`, `mem_we`, `wr_ready`, `rd_ready` forced 0.
  - An in-flight read is dropped, with no response after release.
- Display latency:
  - `pixel` updates at the clk edge ending the `ph==1` cycle, i.e. 2 clk (1 pixel) after `point_pos` is sampled.
  - Downstream sync must be delayed by one `vga_clk`.
- GPU write: takes effect in the RAM on the accept cycle.
- GPU read: `rd_resp_valid` rises exactly 1 clk after the accept cycle.
- Throughput:
  - Active video: at most 1 GPU access per 2 clk.
  - Blanking: 1 GPU access per clk.
- A display slot is never missed or delayed. There is no underrun state.

## Test plan
- Reset release with `blank_n=1`, pos (0,0), RAM[0]=0x5A:
  - Cycle 0 drives `mem_addr=0`, `mem_we=0`.
  - `pixel==0x5A` after 2 clk.
  - `wr_ready` stays low on every `ph==0`.
- Pos (639,479), `blank_n=1` -> `mem_addr==19199`, and `pixel` shows RAM[19199].
- Active video with `wr_valid` and `rd_valid` held:
  - Grants alternate W,R,W,R on `ph==1` cycles only.
  - Read of the just-written address returns the new data 1 clk after the read accept.
- `blank_n=0` with continuous writes:
  - A write is accepted every clk.
  - `pixel==0` from the next `ph==1` edge.
- `wr_addr=19200`:
  - Accepted, `mem_en=0`, `addr_err=1` sticky.
  - A read of 20000 gives `rd_resp_valid=1` with `rd_data=0`.
- Assert `rst` the cycle after a GPU read accept:
  - `rd_resp_valid` never pulses.
  - All outputs are 0, and `ph` restarts at 0.

Source files
------------

// File: rtl/fb_scan_arbiter.sv
// Framebuffer RAM owner: display fetch gets every ph==0 active slot; GPU wr/rd share the rest round-robin.
// Latency: pixel 2 clk after point_pos, GPU read response 1 clk after accept; GPU stalled by ready=0 in display slots.
module fb_scan_arbiter #(
    parameter int FB_W   = 160,
    parameter int FB_H   = 120,
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              blank_n,
    input  logic [9:0]        point_pos_x,
    input  logic [9:0]        point_pos_y,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_resp_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pixel,
    output logic              addr_err
);

    localparam logic [ADDR_W:0] FB_WORDS = (ADDR_W+1)'(FB_W * FB_H);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_GPU  = 2'd2,
        TAG_ZERO = 2'd3
    } tag_t;

    logic              r_ph;
    logic              r_rr;
    tag_t              r_tag;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_rd_data;
    logic [DATA_W-1:0] r_pixel;
    logic              r_addr_err;

    logic              w_disp_slot;
    logic              w_gpu_slot;
    logic              w_wr_gnt;
    logic              w_rd_gnt;
    logic              w_wr_oor;
    logic              w_rd_oor;
    logic [ADDR_W-1:0] w_ys;
    logic [ADDR_W-1:0] w_xs;
    logic [ADDR_W-1:0] w_disp_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] w_wdata_nxt;
    tag_t              w_tag_nxt;

    // Reset gates the slots so nothing reaches the RAM or the GPU while rst is low.
    assign w_disp_slot = rst && !r_ph && blank_n;
    assign w_gpu_slot  = rst && !w_disp_slot;
    assign w_wr_gnt    = w_gpu_slot && wr_valid && (!rd_valid || !r_rr);
    assign w_rd_gnt    = w_gpu_slot && rd_valid && (!wr_valid || r_rr);
    assign w_wr_oor    = {1'b0, wr_addr} >= FB_WORDS;
    assign w_rd_oor    = {1'b0, rd_addr} >= FB_WORDS;

    assign wr_ready    = w_wr_gnt;
    assign rd_ready    = w_rd_gnt;

    // y*160 as shift-add: (y<<7)+(y<<5), after the 4x downscale of both axes.
    assign w_ys        = ADDR_W'(point_pos_y >> 2);
    assign w_xs        = ADDR_W'(point_pos_x >> 2);
    assign w_disp_addr = (w_ys << 7) + (w_ys << 5) + w_xs;

    always_comb begin
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        w_addr_nxt  = r_mem_addr;
        w_wdata_nxt = r_mem_wdata;
        w_tag_nxt   = TAG_NONE;
        if (w_disp_slot) begin
            mem_en     = 1'b1;
            w_addr_nxt = w_disp_addr;
            w_tag_nxt  = TAG_DISP;
        end else if (w_wr_gnt) begin
            if (!w_wr_oor) begin
                mem_en      = 1'b1;
                mem_we      = 1'b1;
                w_addr_nxt  = wr_addr;
                w_wdata_nxt = wr_data;
            end
        end else if (w_rd_gnt) begin
            if (w_rd_oor) begin
                w_tag_nxt = TAG_ZERO;
            end else begin
                mem_en     = 1'b1;
                w_addr_nxt = rd_addr;
                w_tag_nxt  = TAG_GPU;
            end
        end
    end

    assign mem_addr  = w_addr_nxt;
    assign mem_wdata = w_wdata_nxt;

    always_comb begin
        rd_resp_valid = 1'b0;
        rd_data       = r_rd_data;
        case (r_tag)
            TAG_GPU: begin
                rd_resp_valid = 1'b1;
                rd_data       = mem_rdata;
            end
            TAG_ZERO: begin
                rd_resp_valid = 1'b1;
                rd_data       = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ph        <= 1'b0;
            r_rr        <= 1'b0;
            r_tag       <= TAG_NONE;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rd_data   <= '0;
            r_pixel     <= '0;
            r_addr_err  <= 1'b0;
        end else begin
            r_ph        <= ~r_ph;
            r_tag       <= w_tag_nxt;
            r_mem_addr  <= w_addr_nxt;
            r_mem_wdata <= w_wdata_nxt;
            r_rd_data   <= rd_data;
            if (w_gpu_slot && wr_valid && rd_valid)
                r_rr <= ~r_rr;
            if ((w_wr_gnt && w_wr_oor) || (w_rd_gnt && w_rd_oor))
                r_addr_err <= 1'b1;
            if (r_tag == TAG_DISP && blank_n)
                r_pixel <= mem_rdata;
            else if (r_ph && !blank_n)
                r_pixel <= '0;
        end
    end

    assign pixel    = r_pixel;
    assign addr_err = r_addr_err;

endmodule

// File: tb/tb_fb_scan_arbiter.sv
// Directed bench for fb_scan_arbiter with a behavioural 1-cycle synchronous RAM.
module tb_fb_scan_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        blank_n;
    logic [9:0]  point_pos_x, point_pos_y;
    logic        wr_valid, wr_ready, rd_valid, rd_ready;
    logic [14:0] wr_addr, rd_addr, mem_addr;
    logic [7:0]  wr_data, rd_data, mem_wdata, mem_rdata, pixel;
    logic        rd_resp_valid, mem_en, mem_we, addr_err;

    logic [7:0]  ram [0:32767];
    logic        pre_we;
    logic [14:0] pre_addr;
    logic [7:0]  pre_dat;

    int n_cmp = 0;
    int n_bad = 0;
    bit ph;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we)
            ram[pre_addr] <= pre_dat;
        else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    fb_scan_arbiter dut (
        .clk(clk), .rst(rst), .blank_n(blank_n),
        .point_pos_x(point_pos_x), .point_pos_y(point_pos_y),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_resp_valid(rd_resp_valid), .rd_data(rd_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .pixel(pixel), .addr_err(addr_err)
    );

    // Advance one clk and track the expected phase bit.
    task automatic tick();
        logic r;
        @(posedge clk);
        r = rst;
        #1;
        ph = r ? ~ph : 1'b0;
    endtask

    task automatic align();
        if (ph) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; ph = 1'b0; blank_n = 1'b1;
        point_pos_x = 10'd0; point_pos_y = 10'd0;
        wr_valid = 1'b1; wr_addr = 15'd10; wr_data = 8'h00;
        rd_valid = 1'b1; rd_addr = 15'd20;
        pre_we = 1'b1; pre_addr = 15'd0; pre_dat = 8'h5A;
        tick();
        pre_addr = 15'd19199; pre_dat = 8'hC3;
        tick();
        pre_we = 1'b0;
        #1;
        n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL rst_mem_en: got %b want 0", mem_en); end
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
        n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL rst_wr_ready: got %b want 0", wr_ready); end
        n_cmp++; if (rd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_rd_ready: got %b want 0", rd_ready); end
        n_cmp++; if (pixel !== 8'h00) begin n_bad++; $display("FAIL rst_pixel: got %h want 00", pixel); end
        n_cmp++; if (rd_data !== 8'h00) begin n_bad++; $display("FAIL rst_rd_data: got %h want 00", rd_data); end
        n_cmp++; if (rd_resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rd_resp: got %b want 0", rd_resp_valid); end
        n_cmp++; if (addr_err !== 1'b0) begin n_bad++; $display("FAIL rst_addr_err: got %b want 0", addr_err); end
        wr_valid = 1'b0; rd_valid = 1'b0;
    endtask

    task automatic test_display_origin();
        tick();
        rst = 1'b1; ph = 1'b0;
        wr_valid = 1'b1; wr_addr = 15'd500; wr_data = 8'h11;
        #1;
        n_cmp++; if (mem_en !== 1'b1) begin n_bad++; $display("FAIL org_mem_en: got %b want 1", mem_en); end
        n_cmp++; if (mem_addr !== 15'd0) begin n_bad++; $display("FAIL org_mem_addr: got %0d want 0", mem_addr); end
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL org_mem_we: got %b want 0", mem_we); end
        n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL org_wr_ready_ph0: got %b want 0", wr_ready); end
        tick(); #1;
        n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL org_wr_ready_ph1: got %b want 1", wr_ready); end
        n_cmp++; if (mem_addr !== 15'd500) begin n_bad++; $display("FAIL org_wr_addr: got %0d want 500", mem_addr); end
        tick(); #1;
        n_cmp++; if (pixel !== 8'h5A) begin n_bad++; $display("FAIL org_pixel: got %h want 5a", pixel); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL org_wr_ready_ph0_%0d: got %b want 0", i, wr_ready); end
            tick(); tick(); #1;
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_display_corner();
        align();
        point_pos_x = 10'd639; point_pos_y = 10'd479;
        #1;
        n_cmp++; if (mem_addr !== 15'd19199) begin n_bad++; $display("FAIL corner_addr: got %0d want 19199", mem_addr); end
        tick(); tick(); #1;
        n_cmp++; if (pixel !== 8'hC3) begin n_bad++; $display("FAIL corner_pixel: got %h want c3", pixel); end
    endtask

    task automatic test_rr_alternate();
        bit prev_rd, exp_w, exp_r;
        align();
        wr_valid = 1'b1; wr_addr = 15'd300; wr_data = 8'h77;
        rd_valid = 1'b1; rd_addr = 15'd300;
        prev_rd = 1'b0;
        for (int k = 0; k < 9; k++) begin
            #1;
            exp_w = ph && (((k >> 1) % 2) == 0);
            exp_r = ph && (((k >> 1) % 2) == 1);
            n_cmp++; if (wr_ready !== exp_w) begin n_bad++; $display("FAIL rr_wr_ready_%0d: got %b want %b", k, wr_ready, exp_w); end
            n_cmp++; if (rd_ready !== exp_r) begin n_bad++; $display("FAIL rr_rd_ready_%0d: got %b want %b", k, rd_ready, exp_r); end
            n_cmp++; if (rd_resp_valid !== prev_rd) begin n_bad++; $display("FAIL rr_resp_%0d: got %b want %b", k, rd_resp_valid, prev_rd); end
            if (prev_rd) begin
                n_cmp++; if (rd_data !== 8'h77) begin n_bad++; $display("FAIL rr_rd_data_%0d: got %h want 77", k, rd_data); end
            end
            prev_rd = exp_r;
            tick();
        end
        wr_valid = 1'b0; rd_valid = 1'b0;
    endtask

    task automatic test_blanking();
        logic [7:0] exp_pix;
        align();
        blank_n = 1'b0; wr_valid = 1'b1; wr_addr = 15'd1000; wr_data = 8'hA0;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_pix = (i >= 2) ? 8'h00 : 8'hC3;
            n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL blank_wr_ready_%0d: got %b want 1", i, wr_ready); end
            n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL blank_mem_we_%0d: got %b want 1", i, mem_we); end
            n_cmp++; if (mem_addr !== 15'(1000 + i)) begin n_bad++; $display("FAIL blank_addr_%0d: got %0d want %0d", i, mem_addr, 1000 + i); end
            n_cmp++; if (pixel !== exp_pix) begin n_bad++; $display("FAIL blank_pixel_%0d: got %h want %h", i, pixel, exp_pix); end
            tick();
            wr_addr = wr_addr + 15'd1; wr_data = wr_data + 8'd1;
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_addr_err();
        #1;
        n_cmp++; if (addr_err !== 1'b0) begin n_bad++; $display("FAIL oor_pre_err: got %b want 0", addr_err); end
        wr_valid = 1'b1; wr_addr = 15'd19200; wr_data = 8'hFF;
        #1;
        n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL oor_wr_ready: got %b want 1", wr_ready); end
        n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL oor_wr_mem_en: got %b want 0", mem_en); end
        tick();
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 15'd20000;
        #1;
        n_cmp++; if (addr_err !== 1'b1) begin n_bad++; $display("FAIL oor_err_set: got %b want 1", addr_err); end
        n_cmp++; if (rd_ready !== 1'b1) begin n_bad++; $display("FAIL oor_rd_ready: got %b want 1", rd_ready); end
        n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL oor_rd_mem_en: got %b want 0", mem_en); end
        tick();
        rd_valid = 1'b0;
        #1;
        n_cmp++; if (rd_resp_valid !== 1'b1) begin n_bad++; $display("FAIL oor_rd_resp: got %b want 1", rd_resp_valid); end
        n_cmp++; if (rd_data !== 8'h00) begin n_bad++; $display("FAIL oor_rd_data: got %h want 00", rd_data); end
        tick(); #1;
        n_cmp++; if (rd_resp_valid !== 1'b0) begin n_bad++; $display("FAIL oor_rd_resp_end: got %b want 0", rd_resp_valid); end
        n_cmp++; if (addr_err !== 1'b1) begin n_bad++; $display("FAIL oor_err_sticky: got %b want 1", addr_err); end
    endtask

    task automatic test_reset_inflight();
        rd_valid = 1'b1; rd_addr = 15'd300;
        #1;
        n_cmp++; if (rd_ready !== 1'b1) begin n_bad++; $display("FAIL rif_rd_ready: got %b want 1", rd_ready); end
        @(posedge clk); #1;
        rst = 1'b0; ph = 1'b0; rd_valid = 1'b0;
        #1;
        n_cmp++; if (rd_resp_valid !== 1'b0) begin n_bad++; $display("FAIL rif_resp: got %b want 0", rd_resp_valid); end
        n_cmp++; if (rd_data !== 8'h00) begin n_bad++; $display("FAIL rif_rd_data: got %h want 00", rd_data); end
        n_cmp++; if (addr_err !== 1'b0) begin n_bad++; $display("FAIL rif_addr_err: got %b want 0", addr_err); end
        n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL rif_mem_en: got %b want 0", mem_en); end
        n_cmp++; if (pixel !== 8'h00) begin n_bad++; $display("FAIL rif_pixel: got %h want 00", pixel); end
        n_cmp++; if ((wr_ready | rd_ready) !== 1'b0) begin n_bad++; $display("FAIL rif_ready: got %b want 0", wr_ready | rd_ready); end
        tick(); tick(); #1;
        n_cmp++; if (rd_resp_valid !== 1'b0) begin n_bad++; $display("FAIL rif_resp_hold: got %b want 0", rd_resp_valid); end
        tick();
        rst = 1'b1; ph = 1'b0; blank_n = 1'b1;
        point_pos_x = 10'd0; point_pos_y = 10'd0;
        #1;
        n_cmp++; if (mem_en !== 1'b1) begin n_bad++; $display("FAIL rif_ph0_mem_en: got %b want 1", mem_en); end
        n_cmp++; if (mem_addr !== 15'd0) begin n_bad++; $display("FAIL rif_ph0_addr: got %0d want 0", mem_addr); end
        n_cmp++; if (rd_resp_valid !== 1'b0) begin n_bad++; $display("FAIL rif_resp_rel: got %b want 0", rd_resp_valid); end
        tick(); #1;
        n_cmp++; if (rd_resp_valid !== 1'b0) begin n_bad++; $display("FAIL rif_resp_rel2: got %b want 0", rd_resp_valid); end
        tick(); #1;
        n_cmp++; if (pixel !== 8'h5A) begin n_bad++; $display("FAIL rif_pixel_restart: got %h want 5a", pixel); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_display_origin();
        test_display_corner();
        test_rr_alternate();
        test_blanking();
        test_addr_err();
        test_reset_inflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
